axis_noc_inject_arb: RTL and testbench
======================================

// Module: axis_noc_inject_arb
// PURPOSE
//  Packet-level round-robin arbiter sharing one AXI-Stream mesh ingress port (axis_in_*[r][c]) among
//  NUM_REQ traffic sources (num_gen instances, accelerators). A grant is held from first beat to
//  TLAST, so router serialization never sees interleaved packets. Registered output slice toward the NoC.
// PARAMETERS
//  NUM_REQ        4   number of requesters (2..16)
//  TDATAW         32  TDATA width
//  TDESTW         4   TDEST width (mesh router address)
//  MAX_PKT_BEATS  16  beat limit; longer packet sets OVERLONG (2..65535)
// PORTS
//  CLK            in   1               single clock for all logic
//  RST            in   1               synchronous reset, active-high
//  S_TVALID       in   NUM_REQ         per-requester valid
//  S_TREADY       out  NUM_REQ         per-requester ready (only granted bit may be 1)
//  S_TDATA        in   NUM_REQ*TDATAW  requester i at [i*TDATAW +: TDATAW]
//  S_TLAST        in   NUM_REQ         end of packet
//  S_TDEST        in   NUM_REQ*TDESTW  requester i at [i*TDESTW +: TDESTW]
//  M_TVALID       out  1               to mesh axis_in_tvalid
//  M_TREADY       in   1               from mesh axis_in_tready
//  M_TDATA        out  TDATAW          registered data
//  M_TLAST        out  1               registered last
//  M_TDEST        out  TDESTW          registered dest
//  GRANT          out  NUM_REQ         one-hot current owner, 0 when idle
//  OVERLONG       out  1               sticky: a packet exceeded MAX_PKT_BEATS
//  PKT_CNT        out  NUM_REQ*16      per-requester completed packets (ARB_STATS_EN only)
// BEHAVIOUR
//  Reset (RST=1 at CLK edge): state IDLE, GRANT=0, S_TREADY=0, M_TVALID=0, M_TDATA/TLAST/TDEST=0,
//   OVERLONG=0, beat_cnt=0, last_ptr=NUM_REQ-1 (requester 0 has first priority), PKT_CNT=0.
//  Reset mid-packet: output slice and grant drop immediately; in-flight beat discarded (accepted loss).
//  FSM:
//   IDLE   - any S_TVALID: pick first valid index after last_ptr, modulo NUM_REQ; GRANT<=onehot; -> LOCK.
//            No S_TVALID: stay. Arbitration costs 1 cycle; no beat accepted in IDLE.
//   LOCK   - S_TREADY[g] = slot_free, slot_free = !M_TVALID | M_TREADY (combinational through M_TREADY).
//            Beat accepted when S_TVALID[g] & S_TREADY[g]: loads slot, M_TVALID<=1 next cycle.
//            Accepted beat with S_TLAST[g]: last_ptr<=g, GRANT<=0, -> IDLE.
//  Output slice: M_TVALID cleared on M_TREADY when no new beat loaded; M_* stable while M_TVALID & !M_TREADY.
//  Latency: S beat accept -> M_TVALID = 1 cycle. Back-to-back packets from different sources: 1 idle cycle.
//  Dropping S_TVALID[g] mid-packet keeps lock (no re-arbitration until TLAST).
//  beat_cnt: +1 per accepted beat, clears on TLAST beat, saturates at MAX_PKT_BEATS; accepted non-last
//   beat with beat_cnt==MAX_PKT_BEATS-1 sets OVERLONG (sticky until RST). Packet still forwarded whole.
//  Non-granted S_TREADY bits always 0. GRANT never has more than one bit set.
// CONFIGURATION
//  ARB_STATS_EN defined: PKT_CNT[i] +1 (16-bit, wraps 0xFFFF->0) on each accepted TLAST beat from i.
//  ARB_STATS_EN undefined: PKT_CNT port still present, tied to 0; counter logic not built.
// TESTING
//  1 single source: req0 sends 4-beat pkt, TDEST=1, M_TREADY=1 -> GRANT=0001, M beats 1 cycle late, IDLE after.
//  2 all 4 valid with 2-beat pkts -> service order 0,1,2,3,0; never interleaved; 1 gap cycle between pkts.
//  3 M_TREADY low 3 cycles mid-packet -> M_* held constant, S_TREADY[g]=0, no beat lost or duplicated.
//  4 req2 sends 17-beat pkt, MAX_PKT_BEATS=16 -> all 17 beats out, OVERLONG=1 after beat 16, stays 1.
//  5 RST pulse during beat 2 of 3 -> next cycle M_TVALID=0, GRANT=0; following arbitration starts at req0.
//  6 ARB_STATS_EN: 3 pkts req1, 1 pkt req3 -> PKT_CNT[1]=3, PKT_CNT[3]=1, others 0; undefined: all 0.

Source files
------------

// File: rtl/axis_noc_inject_arb.sv
// Packet-level round-robin arbiter feeding one AXI-Stream NoC ingress port through a registered slice.
// Optional per-requester packet counters are built when ARB_STATS_EN is defined.
module axis_noc_inject_arb #(
   parameter int NUM_REQ       = 4,
   parameter int TDATAW        = 32,
   parameter int TDESTW        = 4,
   parameter int MAX_PKT_BEATS = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_REQ-1:0]        S_TVALID,
   output logic [NUM_REQ-1:0]        S_TREADY,
   input  logic [NUM_REQ*TDATAW-1:0] S_TDATA,
   input  logic [NUM_REQ-1:0]        S_TLAST,
   input  logic [NUM_REQ*TDESTW-1:0] S_TDEST,
   output logic                      M_TVALID,
   input  logic                      M_TREADY,
   output logic [TDATAW-1:0]         M_TDATA,
   output logic                      M_TLAST,
   output logic [TDESTW-1:0]         M_TDEST,
   output logic [NUM_REQ-1:0]        GRANT,
   output logic                      OVERLONG,
   output logic [NUM_REQ*16-1:0]     PKT_CNT
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNTW = 16;
   localparam logic [CNTW-1:0] BEAT_MAX = CNTW'(MAX_PKT_BEATS);
   localparam logic [CNTW-1:0] BEAT_WARN = CNTW'(MAX_PKT_BEATS - 1);

   typedef enum logic {ST_IDLE, ST_LOCK} state_t;

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IDXW-1:0]     gidx_q, gidx_d;
   logic [IDXW-1:0]     last_ptr_q, last_ptr_d;
   logic [CNTW-1:0]     beat_cnt_q;
   logic                ovl_q;

   logic                vld_p0;
   logic [TDATAW-1:0]   data_p0;
   logic                last_p0;
   logic [TDESTW-1:0]   dest_p0;

   logic                slot_free, accept, acc_last, pick_found;
   logic [IDXW-1:0]     pick_idx;
   logic                sel_vld, sel_last;
   logic [TDATAW-1:0]   sel_data;
   logic [TDESTW-1:0]   sel_dest;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (v >= BEAT_MAX) ? BEAT_MAX : v + CNTW'(1);
   endfunction

   // Walk downward so the requester nearest after last_ptr is the one left standing.
   always_comb begin
      int idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = int'(last_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (S_TVALID[IDXW'(idx)]) begin
            pick_found = 1'b1;
            pick_idx   = IDXW'(idx);
         end
      end
   end

   always_comb begin
      sel_vld  = 1'b0;
      sel_last = 1'b0;
      sel_data = '0;
      sel_dest = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gidx_q == IDXW'(i)) begin
            sel_vld  = S_TVALID[i];
            sel_last = S_TLAST[i];
            sel_data = S_TDATA[i*TDATAW +: TDATAW];
            sel_dest = S_TDEST[i*TDESTW +: TDESTW];
         end
      end
   end

   assign slot_free = !vld_p0 || M_TREADY;
   assign accept    = (state_q == ST_LOCK) && sel_vld && slot_free;
   assign acc_last  = accept && sel_last;
   assign S_TREADY  = ((state_q == ST_LOCK) && slot_free) ? grant_q : '0;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      last_ptr_d = last_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d = ST_LOCK;
               grant_d = NUM_REQ'(1) << pick_idx;
               gidx_d  = pick_idx;
            end
         end
         ST_LOCK: begin
            if (acc_last) begin
               state_d    = ST_IDLE;
               grant_d    = '0;
               last_ptr_d = gidx_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         last_ptr_q <= IDXW'(NUM_REQ - 1);
         beat_cnt_q <= '0;
         ovl_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         last_ptr_q <= last_ptr_d;
         if (accept) begin
            beat_cnt_q <= sel_last ? '0 : sat_inc(beat_cnt_q);
            if (!sel_last && beat_cnt_q == BEAT_WARN) ovl_q <= 1'b1;
         end
      end
   end

   // Stage p0: registered output slice toward the mesh router.
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
         last_p0 <= 1'b0;
         dest_p0 <= '0;
      end else if (accept) begin
         vld_p0  <= 1'b1;
         data_p0 <= sel_data;
         last_p0 <= sel_last;
         dest_p0 <= sel_dest;
      end else if (M_TREADY) begin
         vld_p0  <= 1'b0;
      end
   end

   assign M_TVALID = vld_p0;
   assign M_TDATA  = data_p0;
   assign M_TLAST  = last_p0;
   assign M_TDEST  = dest_p0;
   assign GRANT    = grant_q;
   assign OVERLONG = ovl_q;

`ifdef ARB_STATS_EN
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
      logic [15:0] cnt_q;
      always_ff @(posedge CLK) begin
         if (RST)                                  cnt_q <= '0;
         else if (acc_last && gidx_q == IDXW'(i))  cnt_q <= cnt_q + 16'd1;
      end
      assign PKT_CNT[i*16 +: 16] = cnt_q;
   end
`else
   assign PKT_CNT = '0;
`endif

endmodule

// File: tb/tb_axis_noc_inject_arb.sv
// Scoreboard bench for axis_noc_inject_arb: per-source beat queues drive S_*, accepted beats are
// queued as expected M_* beats and popped on each M handshake.
module tb_axis_noc_inject_arb;

   localparam int NR  = 4;
   localparam int DW  = 32;
   localparam int TW  = 4;
   localparam int MAX = 16;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
      logic [TW-1:0] t;
   } beat_t;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic [NR-1:0]   S_TVALID = '0;
   logic [NR-1:0]   S_TREADY;
   logic [NR*DW-1:0] S_TDATA = '0;
   logic [NR-1:0]   S_TLAST = '0;
   logic [NR*TW-1:0] S_TDEST = '0;
   logic            M_TVALID;
   logic            M_TREADY = 1'b1;
   logic [DW-1:0]   M_TDATA;
   logic            M_TLAST;
   logic [TW-1:0]   M_TDEST;
   logic [NR-1:0]   GRANT;
   logic            OVERLONG;
   logic [NR*16-1:0] PKT_CNT;

   axis_noc_inject_arb #(.NUM_REQ(NR), .TDATAW(DW), .TDESTW(TW), .MAX_PKT_BEATS(MAX)) dut (
      .CLK(CLK), .RST(RST),
      .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA), .S_TLAST(S_TLAST), .S_TDEST(S_TDEST),
      .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TLAST(M_TLAST), .M_TDEST(M_TDEST),
      .GRANT(GRANT), .OVERLONG(OVERLONG), .PKT_CNT(PKT_CNT)
   );

   always #5 CLK = ~CLK;

   beat_t src_q [NR][$];
   beat_t sb_q [$];
   int    order_q [$];
   int    gap_q [$];
   int    n_tests = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    stall_from = -1;
   int    stall_len = 0;
   int    stall_seen = 0;
   int    owner = -1;
   int    mbeat = 0;
   bit    exp_ovl = 1'b0;
   int    last_acc_cyc = -1;
   bit    prev_stall = 1'b0;
   bit    prev_acc = 1'b0;
   logic [DW-1:0] h_data;
   logic          h_last;
   logic [TW-1:0] h_dest;

   task automatic add_pkt(input int src, input int nb, input logic [TW-1:0] dest, input int tag);
      for (int b = 0; b < nb; b++) begin
         beat_t x;
         x.d = {8'(src), 8'(tag), 16'(b)};
         x.l = (b == nb - 1);
         x.t = dest;
         src_q[src].push_back(x);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NR; i++) src_q[i].delete();
      sb_q.delete();
      order_q.delete();
      gap_q.delete();
      owner = -1;
      mbeat = 0;
      exp_ovl = 1'b0;
      last_acc_cyc = -1;
      prev_stall = 1'b0;
      prev_acc = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      S_TVALID = '0;
      S_TLAST = '0;
      M_TREADY = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      clear_model();
   endtask

   // One iteration per cycle: drive at negedge, observe, then account for the coming posedge.
   task automatic run(input int budget, input int stop_acc);
      int  n;
      int  acc;
      bit  done;
      bit  any_acc;
      beat_t e;
      n = 0;
      acc = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge CLK);
         cyc++;
         for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
               beat_t h;
               h = src_q[i][0];
               S_TVALID[i] = 1'b1;
               S_TDATA[i*DW +: DW] = h.d;
               S_TLAST[i] = h.l;
               S_TDEST[i*TW +: TW] = h.t;
            end else begin
               S_TVALID[i] = 1'b0;
               S_TLAST[i] = 1'b0;
            end
         end
         M_TREADY = !(cyc >= stall_from && cyc < stall_from + stall_len);
         #1;
         n_tests++;
         if (OVERLONG !== exp_ovl) begin
            n_fail++;
            $display("FAIL overlong cyc=%0d got=%b exp=%b", cyc, OVERLONG, exp_ovl);
         end
         n_tests++;
         if (((S_TREADY & ~GRANT) != '0) || !$onehot0(GRANT)) begin
            n_fail++;
            $display("FAIL grant_ready cyc=%0d grant=%b ready=%b", cyc, GRANT, S_TREADY);
         end
         if (prev_stall) begin
            n_tests++;
            if (M_TVALID !== 1'b1 || M_TDATA !== h_data || M_TLAST !== h_last || M_TDEST !== h_dest) begin
               n_fail++;
               $display("FAIL hold cyc=%0d got=%b/%h/%b/%h exp=1/%h/%b/%h", cyc, M_TVALID, M_TDATA,
                        M_TLAST, M_TDEST, h_data, h_last, h_dest);
            end
         end
         if (M_TVALID && !M_TREADY) begin
            stall_seen++;
            n_tests++;
            if (S_TREADY !== '0) begin
               n_fail++;
               $display("FAIL stall_ready cyc=%0d ready=%b exp=0000", cyc, S_TREADY);
            end
         end
         if (prev_acc) begin
            n_tests++;
            if (M_TVALID !== 1'b1) begin
               n_fail++;
               $display("FAIL latency cyc=%0d M_TVALID=%b exp=1", cyc, M_TVALID);
            end
         end
         if (M_TVALID === 1'b1 && M_TREADY) begin
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL extra_beat cyc=%0d data=%h", cyc, M_TDATA);
            end else begin
               e = sb_q.pop_front();
               if (M_TDATA !== e.d || M_TLAST !== e.l || M_TDEST !== e.t) begin
                  n_fail++;
                  $display("FAIL beat cyc=%0d got=%h/%b/%h exp=%h/%b/%h", cyc, M_TDATA, M_TLAST, M_TDEST,
                           e.d, e.l, e.t);
               end
            end
         end
         any_acc = 1'b0;
         for (int i = 0; i < NR; i++) begin
            if (S_TVALID[i] && S_TREADY[i]) begin
               beat_t b;
               b = src_q[i].pop_front();
               any_acc = 1'b1;
               acc++;
               n_tests++;
               if (GRANT !== NR'(1 << i)) begin
                  n_fail++;
                  $display("FAIL grant_owner cyc=%0d grant=%b exp_req=%0d", cyc, GRANT, i);
               end
               if (owner == -1) begin
                  if (last_acc_cyc >= 0) gap_q.push_back(cyc - last_acc_cyc);
                  order_q.push_back(i);
                  owner = i;
               end else begin
                  n_tests++;
                  if (owner != i) begin
                     n_fail++;
                     $display("FAIL interleave cyc=%0d got_req=%0d exp_req=%0d", cyc, i, owner);
                  end
               end
               if (!b.l && mbeat == MAX - 1) exp_ovl = 1'b1;
               mbeat = b.l ? 0 : ((mbeat < MAX) ? mbeat + 1 : mbeat);
               if (b.l) begin
                  owner = -1;
                  last_acc_cyc = cyc;
               end
               sb_q.push_back(b);
            end
         end
         prev_acc = any_acc;
         prev_stall = M_TVALID && !M_TREADY;
         h_data = M_TDATA;
         h_last = M_TLAST;
         h_dest = M_TDEST;
         n++;
         if (stop_acc > 0) begin
            if (acc >= stop_acc) done = 1'b1;
         end else begin
            done = (sb_q.size() == 0) && (M_TVALID === 1'b0);
            for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) done = 1'b0;
         end
         if (!done && n >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout cyc=%0d pending_sb=%0d budget=%0d", cyc, sb_q.size(), budget);
            done = 1'b1;
         end
      end
      M_TREADY = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      #1;
      n_tests++;
      if (GRANT !== '0 || S_TREADY !== '0 || M_TVALID !== 1'b0 || M_TDATA !== '0 || M_TLAST !== 1'b0 ||
          M_TDEST !== '0 || OVERLONG !== 1'b0 || PKT_CNT !== '0) begin
         n_fail++;
         $display("FAIL reset_state grant=%b rdy=%b mv=%b md=%h ml=%b mt=%h ovl=%b pkt=%h exp=all_zero",
                  GRANT, S_TREADY, M_TVALID, M_TDATA, M_TLAST, M_TDEST, OVERLONG, PKT_CNT);
      end
      RST = 1'b0;
      clear_model();
   endtask

   task automatic test_single_source();
      do_reset();
      add_pkt(0, 4, 4'd1, 1);
      run(100, 0);
      n_tests++;
      if (GRANT !== '0 || M_TVALID !== 1'b0 || order_q.size() != 1) begin
         n_fail++;
         $display("FAIL single_idle grant=%b mv=%b pkts=%0d exp=0000/0/1", GRANT, M_TVALID, order_q.size());
      end else if (order_q[0] != 0) begin
         n_fail++;
         $display("FAIL single_owner got=%0d exp=0", order_q[0]);
      end
   endtask

   task automatic test_round_robin();
      int exp_order [5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < NR; i++) add_pkt(i, 2, TW'(i + 8), 2);
      add_pkt(0, 2, 4'd12, 3);
      run(200, 0);
      n_tests++;
      if (order_q.size() != 5) begin
         n_fail++;
         $display("FAIL rr_count got=%0d exp=5", order_q.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (order_q[k] != exp_order[k]) begin
               n_fail++;
               $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, order_q[k], exp_order[k]);
            end
         end
      end
      foreach (gap_q[k]) begin
         n_tests++;
         if (gap_q[k] != 2) begin
            n_fail++;
            $display("FAIL rr_gap idx=%0d got=%0d exp=2", k, gap_q[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      stall_seen = 0;
      add_pkt(1, 8, 4'd5, 4);
      stall_from = cyc + 5;
      stall_len = 3;
      run(200, 0);
      stall_from = -1;
      n_tests++;
      if (stall_seen != 3) begin
         n_fail++;
         $display("FAIL stall_cycles got=%0d exp=3", stall_seen);
      end
   endtask

   task automatic test_overlong();
      add_pkt(2, 17, 4'd9, 5);
      run(200, 0);
      n_tests++;
      if (OVERLONG !== 1'b1 || order_q.size() == 0) begin
         n_fail++;
         $display("FAIL overlong_sticky got=%b exp=1", OVERLONG);
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      add_pkt(1, 1, 4'd2, 6);
      run(100, 0);
      add_pkt(2, 3, 4'd3, 7);
      run(100, 2);
      RST = 1'b1;
      @(negedge CLK);
      #1;
      n_tests++;
      if (M_TVALID !== 1'b0 || GRANT !== '0 || S_TREADY !== '0) begin
         n_fail++;
         $display("FAIL reset_mid mv=%b grant=%b rdy=%b exp=0/0000/0000", M_TVALID, GRANT, S_TREADY);
      end
      RST = 1'b0;
      S_TVALID = '0;
      clear_model();
      add_pkt(3, 1, 4'd4, 8);
      add_pkt(0, 1, 4'd5, 8);
      run(100, 0);
      n_tests++;
      if (order_q.size() != 2) begin
         n_fail++;
         $display("FAIL reset_rr_count got=%0d exp=2", order_q.size());
      end else if (order_q[0] != 0 || order_q[1] != 3) begin
         n_fail++;
         $display("FAIL reset_rr_order got=%0d,%0d exp=0,3", order_q[0], order_q[1]);
      end
   endtask

   task automatic test_stats();
      logic [15:0] exp_cnt [NR];
      logic [15:0] got;
      do_reset();
      add_pkt(1, 1, 4'd1, 9);
      add_pkt(1, 2, 4'd1, 10);
      add_pkt(1, 3, 4'd1, 11);
      add_pkt(3, 2, 4'd6, 12);
      run(200, 0);
`ifdef ARB_STATS_EN
      exp_cnt = '{16'd0, 16'd3, 16'd0, 16'd1};
`else
      exp_cnt = '{16'd0, 16'd0, 16'd0, 16'd0};
`endif
      for (int i = 0; i < NR; i++) begin
         got = PKT_CNT[i*16 +: 16];
         n_tests++;
         if (got !== exp_cnt[i]) begin
            n_fail++;
            $display("FAIL pkt_cnt req=%0d got=%0d exp=%0d", i, got, exp_cnt[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_round_robin();
      test_backpressure();
      test_overlong();
      test_reset_mid_packet();
      test_stats();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d tests=%0d failed=%0d", cyc, n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
